// File: rtl/shift_reg_arb_ctrl.sv
`timescale 1ns/1ps
// Purpose: round-robin arbiter that loads a granted requester word into a shared bidirectional serial shift register.
// Latency: ack in T, shifts T+1..T+WIDTH, CHECK T+WIDTH+1, done T+WIDTH+2 (T+WIDTH+1 without SR_READBACK_CHECK_EN).
// Backpressure: requests are level-held; they are ignored while a transfer is active and served on return to IDLE.
// Optional feature macro: SR_READBACK_CHECK_EN enables the CHECK state, which compares srOut against the captured word.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   reqA/wordA/dirA -> ackA      requester A: level request, word, direction (1=left); one-cycle grant pulse
//   reqB/wordB/dirB -> ackB      requester B: same rules as A
//   srOut                        parallel contents of the attached register
//   srDataIn/srDirection/srShiftEn  serial bit, direction and shift enable to the attached register
//   busy, done, doneId, mismatch transfer status; doneId/mismatch hold until the next done
module shift_reg_arb_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reqA,
  input  logic [WIDTH-1:0] wordA,
  input  logic             dirA,
  output logic             ackA,
  input  logic             reqB,
  input  logic [WIDTH-1:0] wordB,
  input  logic             dirB,
  output logic             ackB,
  input  logic [WIDTH-1:0] srOut,
  output logic             srDataIn,
  output logic             srDirection,
  output logic             srShiftEn,
  output logic             busy,
  output logic             done,
  output logic             doneId,
  output logic             mismatch
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] word_q;     // captured word, reference for read-back
  logic [WIDTH-1:0] tx_q;       // bits still to send, next one at the outgoing end
  logic             dir_q;
  logic             id_q;
  logic             last_grant; // 1 = B was granted last
  logic [CW-1:0]    cnt;
  logic             grant_a, grant_b, grant;
  logic [WIDTH-1:0] gnt_word;
  logic             gnt_dir;
  logic             mismatch_q;

  // Grant only in IDLE; gated by reset so no ack pulses while the block is held in reset.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == IDLE && !reset) begin
      if (reqA && reqB) begin
        grant_a = last_grant;
        grant_b = !last_grant;
      end else begin
        grant_a = reqA;
        grant_b = reqB;
      end
    end
  end

  assign grant    = grant_a | grant_b;
  assign gnt_word = grant_b ? wordB : wordA;
  assign gnt_dir  = grant_b ? dirB  : dirA;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (grant) state_nxt = SHIFT;
      SHIFT: if (cnt == CW'(WIDTH - 1)) begin
`ifdef SR_READBACK_CHECK_EN
        state_nxt = CHECK;
`else
        state_nxt = DONE;
`endif
      end
      CHECK: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      word_q      <= '0;
      tx_q        <= '0;
      dir_q       <= 1'b0;
      id_q        <= 1'b0;
      last_grant  <= 1'b1;
      cnt         <= '0;
      srDataIn    <= 1'b0;
      srDirection <= 1'b0;
      srShiftEn   <= 1'b0;
      doneId      <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      srDataIn  <= 1'b0;
      srShiftEn <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            // First bit is launched on the grant edge so it is present in the first SHIFT cycle.
            word_q      <= gnt_word;
            dir_q       <= gnt_dir;
            id_q        <= grant_b;
            last_grant  <= grant_b;
            cnt         <= '0;
            srShiftEn   <= 1'b1;
            srDirection <= gnt_dir;
            srDataIn    <= gnt_dir ? gnt_word[WIDTH-1] : gnt_word[0];
            tx_q        <= gnt_dir ? {gnt_word[WIDTH-2:0], 1'b0} : {1'b0, gnt_word[WIDTH-1:1]};
          end
        end
        SHIFT: begin
          if (cnt != CW'(WIDTH - 1)) begin
            // Left shifts take MSB first, right shifts LSB first, so the word lands unreversed.
            cnt       <= cnt + CW'(1);
            srShiftEn <= 1'b1;
            srDataIn  <= dir_q ? tx_q[WIDTH-1] : tx_q[0];
            tx_q      <= dir_q ? {tx_q[WIDTH-2:0], 1'b0} : {1'b0, tx_q[WIDTH-1:1]};
          end
        end
`ifdef SR_READBACK_CHECK_EN
        CHECK: mismatch_q <= (srOut != word_q);
`endif
        default: ;
      endcase
      if (state_nxt == DONE) doneId <= id_q;
    end
  end

`ifdef SR_READBACK_CHECK_EN
  assign mismatch = mismatch_q;
`else
  logic unused_readback;
  assign unused_readback = ^{srOut, word_q, mismatch_q};
  assign mismatch = 1'b0;
`endif

  assign ackA = grant_a;
  assign ackB = grant_b;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shift_reg_arb_ctrl.sv
`timescale 1ns/1ps
module tb_shift_reg_arb_ctrl;
  localparam int WIDTH = 8;
`ifdef SR_READBACK_CHECK_EN
  localparam int LAT_DONE = WIDTH + 2;
  localparam bit CHK = 1'b1;
`else
  localparam int LAT_DONE = WIDTH + 1;
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reqA = 1'b0, reqB = 1'b0, dirA = 1'b0, dirB = 1'b0;
  logic [WIDTH-1:0] wordA = '0, wordB = '0;
  logic ackA, ackB, srDataIn, srDirection, srShiftEn, busy, done, doneId, mismatch;
  logic [WIDTH-1:0] srOut;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_reg_arb_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .reqA(reqA), .wordA(wordA), .dirA(dirA), .ackA(ackA),
    .reqB(reqB), .wordB(wordB), .dirB(dirB), .ackB(ackB),
    .srOut(srOut), .srDataIn(srDataIn), .srDirection(srDirection), .srShiftEn(srShiftEn),
    .busy(busy), .done(done), .doneId(doneId), .mismatch(mismatch)
  );

  // Behavioural shift register; optional readback fault with bit 3 stuck at 0.
  logic [WIDTH-1:0] sr_q = '0;
  logic stuck3 = 1'b0;
  always @(posedge clk) begin
    if (srShiftEn) sr_q <= srDirection ? {sr_q[WIDTH-2:0], srDataIn} : {srDataIn, sr_q[WIDTH-1:1]};
  end
  assign srOut = stuck3 ? (sr_q & ~(WIDTH'(8))) : sr_q;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] word;
    logic             mm;
  } exp_t;

  exp_t exp_q[$];
  logic bit_q[$];
  logic gnt_q[$];

  task automatic push_xfer(input logic id, input logic [WIDTH-1:0] w, input logic d, input logic mm);
    exp_t e;
    e.id = id; e.word = w; e.mm = mm;
    exp_q.push_back(e);
    gnt_q.push_back(id);
    for (int k = 0; k < WIDTH; k++) bit_q.push_back(d ? w[WIDTH-1-k] : w[k]);
  endtask

  task automatic test_reset();
    reset = 1'b1; reqA = 1'b1;
    #2;
    checks++;
    if ({ackA, ackB, srDataIn, srDirection, srShiftEn, busy, done, doneId, mismatch} !== 9'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0", {ackA, ackB, srDataIn, srDirection, srShiftEn, busy, done, doneId, mismatch});
    end
    @(negedge clk);
    checks++;
    if ({ackA, busy, srShiftEn} !== 3'b0) begin
      failures++;
      $display("FAIL reset_held got=%b want=000", {ackA, busy, srShiftEn});
    end
    reqA = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({ackA, ackB, busy, done} !== 4'b0) begin
      failures++;
      $display("FAIL reset_idle got=%b want=0000", {ackA, ackB, busy, done});
    end
  endtask

  task automatic test_single_xfer(input logic id, input logic [WIDTH-1:0] w, input logic d, input logic mm);
    bit   got;
    exp_t e;
    logic b;
    push_xfer(id, w, d, mm);
    void'(gnt_q.pop_back());
    @(posedge clk); #1;
    if (id) begin reqB = 1'b1; wordB = w; dirB = d; end
    else    begin reqA = 1'b1; wordA = w; dirA = d; end
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ackA || ackB) begin got = 1'b1; break; end
    end
    checks++;
    if (!got || {ackA, ackB} !== (id ? 2'b01 : 2'b10)) begin
      failures++;
      $display("FAIL single_ack id=%0d got=%b want=%b", id, {ackA, ackB}, (id ? 2'b01 : 2'b10));
      exp_q.delete(); bit_q.delete();
      reqA = 1'b0; reqB = 1'b0;
      return;
    end
    @(posedge clk); #1 reqA = 1'b0; reqB = 1'b0;
    for (int c = 1; c <= LAT_DONE + 1; c++) begin
      @(negedge clk);
      if (c <= WIDTH) begin
        b = (bit_q.size() > 0) ? bit_q.pop_front() : 1'bx;
        checks++;
        if ({srShiftEn, srDirection, srDataIn, busy, done, ackA, ackB} !== {1'b1, d, b, 1'b1, 3'b000}) begin
          failures++;
          $display("FAIL shift_cycle c=%0d got=%b want=%b", c,
                   {srShiftEn, srDirection, srDataIn, busy, done, ackA, ackB}, {1'b1, d, b, 1'b1, 3'b000});
        end
      end else if (c < LAT_DONE) begin
        checks++;
        if ({srShiftEn, srDirection, srDataIn, busy, done, ackA, ackB} !== {1'b0, d, 1'b0, 1'b1, 3'b000}) begin
          failures++;
          $display("FAIL check_cycle c=%0d got=%b want=%b", c,
                   {srShiftEn, srDirection, srDataIn, busy, done, ackA, ackB}, {1'b0, d, 1'b0, 1'b1, 3'b000});
        end
      end else if (c == LAT_DONE) begin
        e = exp_q.pop_front();
        checks++;
        if ({srShiftEn, srDataIn, done, doneId, mismatch} !== {3'b001, e.id, e.mm}) begin
          failures++;
          $display("FAIL done_cycle c=%0d got=%b want=%b", c,
                   {srShiftEn, srDataIn, done, doneId, mismatch}, {3'b001, e.id, e.mm});
        end
        checks++;
        if (sr_q !== e.word) begin
          failures++;
          $display("FAIL model_word got=%h want=%h", sr_q, e.word);
        end
      end else begin
        checks++;
        if ({busy, done, doneId, mismatch} !== {2'b00, id, mm}) begin
          failures++;
          $display("FAIL after_done got=%b want=%b", {busy, done, doneId, mismatch}, {2'b00, id, mm});
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int   acks, shifts, cyc;
    logic g;
    exp_t e;
    logic b;
    reset = 1'b1;
    reqA = 1'b1; wordA = 8'h5A; dirA = 1'b1;
    reqB = 1'b1; wordB = 8'hC3; dirB = 1'b0;
    for (int i = 0; i < 4; i++)
      push_xfer(i[0], i[0] ? 8'hC3 : 8'h5A, !i[0], 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    acks = 0; shifts = 0; cyc = 0;
    while ((acks < 4 || exp_q.size() > 0) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ackA || ackB) begin
        g = (gnt_q.size() > 0) ? gnt_q.pop_front() : 1'bx;
        checks++;
        if ({ackA, ackB, busy, srShiftEn} !== {!g, g, 2'b00}) begin
          failures++;
          $display("FAIL rr_grant n=%0d got=%b want=%b", acks, {ackA, ackB, busy, srShiftEn}, {!g, g, 2'b00});
        end
        if (acks > 0) begin
          checks++;
          if (shifts !== WIDTH) begin
            failures++;
            $display("FAIL rr_window n=%0d shifts=%0d want=%0d", acks, shifts, WIDTH);
          end
        end
        shifts = 0;
        acks++;
        if (acks == 4) begin
          @(posedge clk); #1 reqA = 1'b0; reqB = 1'b0;
        end
      end else if (srShiftEn) begin
        shifts++;
        b = (bit_q.size() > 0) ? bit_q.pop_front() : 1'bx;
        checks++;
        if (srDataIn !== b) begin
          failures++;
          $display("FAIL rr_bit n=%0d got=%b want=%b", acks, srDataIn, b);
        end
      end
      if (done) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : exp_t'('x);
        checks++;
        if ({doneId, mismatch} !== {e.id, e.mm} || sr_q !== e.word) begin
          failures++;
          $display("FAIL rr_done got=%b/%h want=%b/%h", {doneId, mismatch}, sr_q, {e.id, e.mm}, e.word);
        end
      end
    end
    checks++;
    if (cyc >= 200 || shifts !== WIDTH) begin
      failures++;
      $display("FAIL rr_complete cycles=%0d acks=%0d last_shifts=%0d want acks=4 shifts=%0d", cyc, acks, shifts, WIDTH);
    end
    exp_q.delete(); bit_q.delete(); gnt_q.delete();
  endtask

  task automatic test_readback_fault();
    stuck3 = 1'b1;
    test_single_xfer(1'b0, 8'hFF, 1'b1, CHK);
    stuck3 = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit   got;
    int   shifts;
    logic b;
    exp_t e;
    @(posedge clk); #1 reqA = 1'b1; wordA = 8'h81; dirA = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ackA) begin got = 1'b1; break; end
    end
    shifts = 0;
    for (int i = 0; i < 10 && shifts < 4; i++) begin
      @(negedge clk);
      if (srShiftEn) shifts++;
    end
    checks++;
    if (!got || shifts != 4) begin
      failures++;
      $display("FAIL mid_setup acked=%0d shifts=%0d want 1/4", got, shifts);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({ackA, ackB, srDataIn, srDirection, srShiftEn, busy, done, doneId, mismatch} !== 9'b0) begin
      failures++;
      $display("FAIL mid_reset got=%b want=0", {ackA, ackB, srDataIn, srDirection, srShiftEn, busy, done, doneId, mismatch});
    end
    push_xfer(1'b0, 8'h81, 1'b1, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({ackA, ackB, busy} !== 3'b100) begin
      failures++;
      $display("FAIL mid_regrant got=%b want=100", {ackA, ackB, busy});
    end
    @(posedge clk); #1 reqA = 1'b0;
    shifts = 0;
    for (int c = 1; c <= LAT_DONE; c++) begin
      @(negedge clk);
      if (srShiftEn) begin
        shifts++;
        b = (bit_q.size() > 0) ? bit_q.pop_front() : 1'bx;
        checks++;
        if (srDataIn !== b) begin
          failures++;
          $display("FAIL mid_bit c=%0d got=%b want=%b", c, srDataIn, b);
        end
      end
      if (c < LAT_DONE) begin
        checks++;
        if (done !== 1'b0) begin
          failures++;
          $display("FAIL mid_early_done c=%0d got=1 want=0", c);
        end
      end else begin
        e = exp_q.pop_front();
        checks++;
        if ({done, doneId, mismatch, shifts} !== {1'b1, e.id, e.mm, 32'(WIDTH)} || sr_q !== e.word) begin
          failures++;
          $display("FAIL mid_done got=%b%b%b shifts=%0d sr=%h want=1%b%b shifts=%0d sr=%h",
                   done, doneId, mismatch, shifts, sr_q, e.id, e.mm, WIDTH, e.word);
        end
      end
    end
    exp_q.delete(); bit_q.delete(); gnt_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_xfer(1'b0, 8'hA5, 1'b1, 1'b0);
    test_single_xfer(1'b1, 8'h3C, 1'b0, 1'b0);
    test_round_robin();
    test_readback_fault();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
